// File: rtl/ps2_pkg.sv
// Shared constants, receiver state encoding and the scancode set 2 to ASCII
// translation table for the PS/2 keyboard front end.
package ps2_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_F0     = 8'hF0;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [7:0] K_UP      = 8'h80;
  localparam logic [7:0] K_DOWN    = 8'h81;
  localparam logic [7:0] K_LEFT    = 8'h82;
  localparam logic [7:0] K_RIGHT   = 8'h83;
  localparam logic [7:0] K_ENTER   = 8'h0D;
  localparam logic [7:0] K_BS      = 8'h08;
  localparam logic [7:0] K_ESC     = 8'h1B;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // Returns {valid, ascii}. Letters always come back lowercase; the caller
  // applies caps/shift/ctrl to them.
  function automatic logic [8:0] translate(input logic [7:0] code,
                                           input logic shift,
                                           input logic ext);
    logic       v;
    logic [7:0] a;
    v = 1'b1;
    a = 8'h00;
    if (ext) begin
      case (code)
        8'h75:   a = K_UP;
        8'h72:   a = K_DOWN;
        8'h6B:   a = K_LEFT;
        8'h74:   a = K_RIGHT;
        8'h5A:   a = K_ENTER;
        default: v = 1'b0;
      endcase
    end else begin
      case (code)
        8'h1C: a = "a";  8'h32: a = "b";  8'h21: a = "c";  8'h23: a = "d";
        8'h24: a = "e";  8'h2B: a = "f";  8'h34: a = "g";  8'h33: a = "h";
        8'h43: a = "i";  8'h3B: a = "j";  8'h42: a = "k";  8'h4B: a = "l";
        8'h3A: a = "m";  8'h31: a = "n";  8'h44: a = "o";  8'h4D: a = "p";
        8'h15: a = "q";  8'h2D: a = "r";  8'h1B: a = "s";  8'h2C: a = "t";
        8'h3C: a = "u";  8'h2A: a = "v";  8'h1D: a = "w";  8'h22: a = "x";
        8'h35: a = "y";  8'h1A: a = "z";
        8'h16: a = shift ? "!" : "1";
        8'h1E: a = shift ? "@" : "2";
        8'h26: a = shift ? "#" : "3";
        8'h25: a = shift ? "$" : "4";
        8'h2E: a = shift ? "%" : "5";
        8'h36: a = shift ? "^" : "6";
        8'h3D: a = shift ? "&" : "7";
        8'h3E: a = shift ? "*" : "8";
        8'h46: a = shift ? "(" : "9";
        8'h45: a = shift ? ")" : "0";
        8'h0E: a = shift ? "~" : 8'h60;
        8'h4E: a = shift ? "_" : "-";
        8'h55: a = shift ? "+" : "=";
        8'h54: a = shift ? "{" : "[";
        8'h5B: a = shift ? "}" : "]";
        8'h5D: a = shift ? "|" : "\\";
        8'h4C: a = shift ? ":" : ";";
        8'h52: a = shift ? "\"" : "'";
        8'h41: a = shift ? "<" : ",";
        8'h49: a = shift ? ">" : ".";
        8'h4A: a = shift ? "?" : "/";
        8'h29: a = 8'h20;
        8'h5A: a = K_ENTER;
        8'h66: a = K_BS;
        8'h0D: a = 8'h09;
        8'h76: a = K_ESC;
        default: v = 1'b0;
      endcase
    end
    return {v, a};
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronisers, clock glitch filter, 11-bit frame
// FSM with odd-parity/stop checking and an inactivity watchdog.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 25000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] data,
  output logic       strobe,
  output logic       err
);
  localparam int FW = $clog2(FILTER + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_filt, fall;
  logic [FW-1:0] filt_cnt;
  logic [WW-1:0] wd_cnt;
  logic [2:0]    bit_cnt;
  logic          parity, wd_expired, strobe_next, err_next;
  rx_state_t     state_reg, state_next;

  // Filtered clock idles high so reset never produces a phantom falling edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      fall     <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
        fall     <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign wd_expired = (state_reg != RX_IDLE) && (wd_cnt == WW'(TIMEOUT - 1));

  always_comb begin
    state_next  = state_reg;
    strobe_next = 1'b0;
    err_next    = 1'b0;
    if (fall) begin
      case (state_reg)
        RX_IDLE:   if (!dat_sync[1]) state_next = RX_DATA;
        RX_DATA:   if (bit_cnt == 3'd7) state_next = RX_PARITY;
        RX_PARITY: state_next = RX_STOP;
        RX_STOP: begin
          state_next = RX_IDLE;
          if (dat_sync[1] && (^{data, parity})) strobe_next = 1'b1;
          else err_next = 1'b1;
        end
        default:   state_next = RX_IDLE;
      endcase
    end else if (wd_expired) begin
      state_next = RX_IDLE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= RX_IDLE;
      data      <= 8'h00;
      bit_cnt   <= 3'd0;
      parity    <= 1'b0;
      strobe    <= 1'b0;
      err       <= 1'b0;
      wd_cnt    <= '0;
    end else begin
      state_reg <= state_next;
      strobe    <= strobe_next;
      err       <= err_next;
      if (fall || state_reg == RX_IDLE) wd_cnt <= '0;
      else wd_cnt <= wd_cnt + WW'(1);
      if (fall) begin
        case (state_reg)
          RX_IDLE:   bit_cnt <= 3'd0;
          RX_DATA: begin
            data    <= {dat_sync[1], data[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          RX_PARITY: parity <= dat_sync[1];
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end: receives set 2 scancodes, tracks prefixes and
// modifiers, and emits one kdone strobe with an ASCII code per key make.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 25000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       kdone,
  output logic [7:0] ascii,
  output logic       err
);
  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       brk, ext, lshift, rshift, ctrl, caps;
  logic [2:0] skip;
  logic       shift, is_letter;
  logic [8:0] base, glyph;
  logic [7:0] key;

  ps2_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) u_rx (
    .clock   (clock),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .data    (rx_byte),
    .strobe  (rx_strobe),
    .err     (err)
  );

  assign shift = lshift | rshift;

  // Ctrl+letter gives the control code; uppercase and lowercase share it.
  always_comb begin
    base      = translate(rx_byte, 1'b0, ext);
    glyph     = translate(rx_byte, shift, ext);
    is_letter = base[8] && !ext && (base[7:0] >= "a") && (base[7:0] <= "z");
    key       = glyph[7:0];
    if (is_letter) begin
      if (ctrl)              key = base[7:0] & 8'h1F;
      else if (shift ^ caps) key = base[7:0] - 8'h20;
      else                   key = base[7:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kdone  <= 1'b0;
      ascii  <= 8'h00;
      brk    <= 1'b0;
      ext    <= 1'b0;
      lshift <= 1'b0;
      rshift <= 1'b0;
      ctrl   <= 1'b0;
      caps   <= 1'b0;
      skip   <= 3'd0;
    end else begin
      kdone <= 1'b0;
      if (rx_strobe) begin
        if (skip != 3'd0) begin
          skip <= skip - 3'd1;
        end else if (rx_byte == SC_E1) begin
          skip <= 3'd7;
        end else if (rx_byte == SC_E0) begin
          ext <= 1'b1;
        end else if (rx_byte == SC_F0) begin
          brk <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
          // Extended shift codes are the keyboard's fake shifts and are dropped.
          case (rx_byte)
            SC_LSHIFT: if (!ext) lshift <= !brk;
            SC_RSHIFT: if (!ext) rshift <= !brk;
            SC_CTRL:   ctrl <= !brk;
            SC_CAPS:   if (!brk) caps <= !caps;
            default: begin
              if (!brk && glyph[8]) begin
                kdone <= 1'b1;
                ascii <= key;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Scoreboard bench for ps2_keyboard: stimulus pushes expected codes, a
// negedge monitor compares them against each kdone/err strobe.
module tb_ps2_keyboard;
  // PS/2 bit period and watchdog are scaled down to keep the run short.
  localparam int HALF    = 20;
  localparam int TIMEOUT = 600;

  logic       clock   = 1'b0;
  logic       reset   = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       kdone, err;
  logic [7:0] ascii;

  int         checks = 0;
  int         errors = 0;
  int         rd_idx = 0;
  int         zero_req = 0;
  int         zero_ack = 0;
  logic       fin_req = 1'b0;
  logic       fin_ack = 1'b0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_got;

  ps2_keyboard #(.FILTER(8), .TIMEOUT(TIMEOUT)) dut (
    .clock   (clock),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .kdone   (kdone),
    .ascii   (ascii),
    .err     (err)
  );

  always #20 clock = ~clock;

  // Monitor: the only process that steps the counters.
  always @(negedge clock) begin
    if (zero_req != zero_ack) begin
      checks <= checks + 1;
      if (kdone !== 1'b0 || err !== 1'b0 || ascii !== 8'h00) begin
        errors <= errors + 1;
        $display("FAIL reset_state got kdone=%b err=%b ascii=%h required kdone=0 err=0 ascii=00",
                 kdone, err, ascii);
      end else begin
        $display("reset_state ok kdone=0 err=0 ascii=00");
      end
      zero_ack <= zero_ack + 1;
    end else if (fin_req && !fin_ack) begin
      checks <= checks + 1;
      if (rd_idx != exp_q.size()) begin
        errors <= errors + 1;
        $display("FAIL missing_events got=%0d required=%0d", rd_idx, exp_q.size());
      end
      fin_ack <= 1'b1;
    end else if (!reset && (kdone || err)) begin
      mon_got = err ? 9'h100 : {1'b0, ascii};
      checks <= checks + 1;
      if (rd_idx >= exp_q.size()) begin
        errors <= errors + 1;
        $display("FAIL unexpected_event got=%h required=none", mon_got);
      end else begin
        if (mon_got !== exp_q[rd_idx]) begin
          errors <= errors + 1;
          $display("FAIL event%0d got=%h required=%h", rd_idx, mon_got, exp_q[rd_idx]);
        end else begin
          $display("event%0d ok got=%h", rd_idx, mon_got);
        end
        rd_idx <= rd_idx + 1;
      end
    end
  end

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      ps2_dat = f[i];
      repeat (HALF) @(negedge clock);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clock);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic flip);
    send_bits({1'b1, (~^b) ^ flip, b, 1'b0}, 11);
    repeat (2 * HALF) @(negedge clock);
  endtask

  task automatic key(input logic [7:0] b);
    send(b, 1'b0);
  endtask

  task automatic key_exp(input logic [7:0] b, input logic [7:0] a);
    exp_q.push_back({1'b0, a});
    send(b, 1'b0);
  endtask

  task automatic zero_check();
    zero_req++;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    zero_check();

    key_exp(8'h1C, 8'h61);

    key(8'h12); key_exp(8'h1C, 8'h41);
    key(8'hF0); key(8'h1C); key(8'hF0); key(8'h12);
    key_exp(8'h1C, 8'h61);

    key(8'h58); key(8'hF0); key(8'h58);
    key_exp(8'h1C, 8'h41);
    key(8'h12); key_exp(8'h1C, 8'h61);
    key_exp(8'h16, 8'h21);
    key(8'hF0); key(8'h12); key(8'h58); key(8'hF0); key(8'h58);

    exp_q.push_back(9'h100);
    send(8'h1C, 1'b1);
    key_exp(8'h29, 8'h20);

    send_bits({1'b1, ~^8'h29, 8'h29, 1'b0}, 5);
    repeat (1000) @(negedge clock);
    key_exp(8'h29, 8'h20);

    send_bits({1'b1, ~^8'h1C, 8'h1C, 1'b0}, 5);
    reset = 1'b1;
    ps2_dat = 1'b1;
    repeat (2) @(negedge clock);
    zero_check();
    reset = 1'b0;
    repeat (2 * HALF) @(negedge clock);

    key(8'hE0); key_exp(8'h75, 8'h80);
    key(8'hE0); key(8'hF0); key(8'h75);
    key(8'h14); key_exp(8'h21, 8'h03);
    key(8'hF0); key(8'h14);
    key(8'hE1); key(8'h14); key(8'h77); key(8'hE1);
    key(8'hF0); key(8'h14); key(8'hF0); key(8'h77);
    key_exp(8'h1C, 8'h61);

    key(8'hE0); key(8'h12); key_exp(8'h1C, 8'h61);
    key(8'hE0); key(8'hF0); key(8'h12);
    key(8'h07); key_exp(8'h5A, 8'h0D);

    repeat (20) @(negedge clock);
    fin_req = 1'b1;
    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
Upstream feeder of the I/O port block's keyboard inputs. Receives PS/2 scancode set 2 frames from the keyboard pins and tracks modifier and prefix state. Translates make codes to 8-bit ASCII and emits one `kdone` pulse per translated key. Runs on the 25 MHz system clock.

Parameters:
- FILTER, 8, number of consecutive equal samples required before the synchronised ps2_clk level is accepted.
- TIMEOUT, 25000, idle cycles (1 ms at 25 MHz) after which a partial frame is discarded.

Ports:
- clock  in  1  system clock, 25 MHz.
- reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin (asynchronous).
- ps2_dat  in  1  raw PS/2 data pin (asynchronous).
- kdone  out  1  one-cycle strobe: a new ASCII code is present on `ascii`.
- ascii  out  8  translated code; holds its value until the next `kdone`.
- err  out  1  one-cycle strobe on a parity or stop-bit error.

Behaviour:
- Reset: kdone=0, err=0, ascii=8'h00, receiver in IDLE, all flags (brk, ext, lshift, rshift, ctrl, caps, skip counter) cleared. Reset applied mid-frame discards that frame.
- Input conditioning: 2-FF synchroniser on both pins. The filtered clock changes only after FILTER equal samples. A falling edge of the filtered clock is the sampling point for ps2_dat.
- Receiver FSM, on each falling edge:
  - IDLE: dat=0 → DATA with bit count 0. dat=1 → stay in IDLE.
  - DATA: shift in LSB first; after bit 7 → PARITY.
  - PARITY: latch the bit → STOP.
  - STOP: if parity is odd over data+parity and dat=1, pulse the internal byte strobe next cycle. Otherwise pulse err. Either way → IDLE.
  - Watchdog: counter cleared on every falling edge. If TIMEOUT cycles pass outside IDLE → IDLE, no strobe, no err.
- Decoder, on byte strobe:
  - Skip counter nonzero → decrement and discard.
  - E1 → skip=7; this discards the Pause sequence.
  - E0 → ext=1.
  - F0 → brk=1.
  - Any other byte → process, then clear brk and ext.
- Modifiers:
  - 12 → lshift, 59 → rshift, 14 → ctrl (with or without E0). Each is set on make and cleared on break.
  - E0 12 / E0 F0 12 (fake shift) are ignored.
  - 58 toggles caps on make only.
  - Modifier bytes never generate kdone.
- Break of any non-modifier key: no output.
- Make translation:
  - Letters: uppercase if (lshift|rshift) XOR caps, else lowercase.
  - Digits and punctuation: shifted glyph if lshift|rshift (US layout).
  - Specials: 29→20h, 5A→0Dh, 66→08h, 0D→09h, 76→1Bh.
  - Extended keys: E0 75→80h, E0 72→81h, E0 6B→82h, E0 74→83h, E0 5A→0Dh.
  - With ctrl=1 and a letter: ascii = uppercase & 1Fh.
  - Unmapped code: no kdone, ascii unchanged.
- Latency: kdone and ascii update together 2 cycles after the STOP-bit falling edge (cycle 1 byte strobe, cycle 2 registered output). Typematic repeats produce one kdone per make byte.
- No backpressure: the consumer latches on kdone. A new code overwrites ascii.

Decomposition:
- Package `ps2_pkg`:
  - Prefix constants (E0, E1, F0).
  - Modifier scancodes (12, 59, 14, 58).
  - Special ASCII constants (K_UP=80h, K_DOWN=81h, K_LEFT=82h, K_RIGHT=83h, K_ENTER=0Dh, K_BS=08h, K_ESC=1Bh).
  - Receiver state enum.
  - Translation function: (scancode, shift, ext) → {valid, ascii}.
- Sub-module `ps2_rx`: synchroniser, filter, frame FSM and watchdog. Outputs byte[7:0], a strobe and err. The decoder stays in ps2_keyboard.

Test Plan:
- Frame 1C with correct parity, bit period 80 us → exactly one kdone, ascii=61h, err stays 0.
- Sequence 12, 1C, F0 1C, F0 12, 1C → ascii 41h then 61h, two kdone pulses total.
- 58, F0 58, 1C, then 12, 1C → 41h then 61h (caps XOR shift); 16 with shift held → 21h.
- Frame 1C with parity bit inverted → err pulse, no kdone. Next valid frame 29 → ascii=20h.
- First 5 bits of a frame, wait 1.2 ms, then a full 29 frame → one kdone with ascii=20h, no err. Also assert reset mid-frame → all outputs 0.
- Extended and control sequences:
  - E0 75 → 80h.
  - E0 F0 75 → nothing.
  - 14, 21 → 03h.
  - E1 14 77 E1 F0 14 F0 77 → no kdone.
  - A following 1C → 61h.
